// File: rtl/sme_driver.sv
// Buffers one string and one pattern from the host, then serializes them to the matcher and reports its result.
// Latency: first char one cycle after the accepted start; done two cycles after sme_valid; no backpressure, busy blocks new jobs.
module sme_driver #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [5:0] str_len,
    input  logic [3:0] pat_len,
    input  logic       start,
    input  logic       send_str,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_index,
    output logic       busy,
    output logic       done,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_timeout
);
    localparam int SW = $clog2(STR_MAX);
    localparam int PW = $clog2(PAT_MAX);
    localparam logic [5:0] STR_LIM = 6'(STR_MAX);
    localparam logic [3:0] PAT_LIM = 4'(PAT_MAX);
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SEND_S, SEND_P, WAIT, DONE} state_t;

    state_t     state;
    logic [7:0] str_buf [STR_MAX];
    logic [7:0] pat_buf [PAT_MAX];
    logic       str_loaded;
    logic [5:0] s_len;
    logic [3:0] p_len;
    logic [5:0] cnt;
    logic [7:0] wdog;
    logic       cap_match;
    logic [4:0] cap_index;
    logic       cap_timeout;

    logic       go_str;
    logic       reject;
    logic [5:0] s_len_c;
    logic [3:0] p_len_c;

    // A pattern-only request still sends the string if none has been sent since reset.
    always_comb begin
        go_str  = send_str || !str_loaded;
        reject  = (pat_len == 4'd0) || (go_str && (str_len == 6'd0));
        s_len_c = (str_len > STR_LIM) ? STR_LIM : str_len;
        p_len_c = (pat_len > PAT_LIM) ? PAT_LIM : pat_len;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            str_loaded  <= 1'b0;
            s_len       <= '0;
            p_len       <= '0;
            cnt         <= '0;
            wdog        <= '0;
            cap_match   <= 1'b0;
            cap_index   <= '0;
            cap_timeout <= 1'b0;
            chardata    <= '0;
            isstring    <= 1'b0;
            ispattern   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            res_match   <= 1'b0;
            res_index   <= '0;
            res_timeout <= 1'b0;
            for (int i = 0; i < STR_MAX; i++) str_buf[i] <= '0;
            for (int i = 0; i < PAT_MAX; i++) pat_buf[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        if (wr_sel) pat_buf[wr_addr[PW-1:0]] <= wr_data;
                        else        str_buf[wr_addr[SW-1:0]] <= wr_data;
                    end
                    if (start && !reject) begin
                        s_len <= s_len_c;
                        p_len <= p_len_c;
                        cnt   <= '0;
                        state <= go_str ? SEND_S : SEND_P;
                    end
                end
                SEND_S: begin
                    chardata   <= str_buf[cnt[SW-1:0]];
                    isstring   <= 1'b1;
                    ispattern  <= 1'b0;
                    busy       <= 1'b1;
                    str_loaded <= 1'b1;
                    if (cnt + 6'd1 == s_len) begin
                        cnt   <= '0;
                        state <= SEND_P;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                SEND_P: begin
                    chardata  <= pat_buf[cnt[PW-1:0]];
                    isstring  <= 1'b0;
                    ispattern <= 1'b1;
                    busy      <= 1'b1;
                    if (cnt + 6'd1 == {2'b00, p_len}) begin
                        cnt   <= '0;
                        wdog  <= '0;
                        state <= WAIT;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                WAIT: begin
                    chardata  <= '0;
                    isstring  <= 1'b0;
                    ispattern <= 1'b0;
                    // A result arriving on the watchdog's last cycle is still taken.
                    if (sme_valid) begin
                        cap_match   <= sme_match;
                        cap_index   <= sme_index;
                        cap_timeout <= 1'b0;
                        state       <= DONE;
                    end else if (wdog == WD_LAST) begin
                        cap_match   <= 1'b0;
                        cap_index   <= '0;
                        cap_timeout <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                DONE: begin
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    res_match   <= cap_match;
                    res_index   <= cap_index;
                    res_timeout <= cap_timeout;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sme_driver.sv
// Directed bench for sme_driver: full job, pattern reuse, timeout, rejects/ignores, reset mid-job.
module tb_sme_driver;
    logic       clk, reset, wr_en, wr_sel, start, send_str;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [5:0] str_len;
    logic [3:0] pat_len;
    logic [7:0] chardata;
    logic       isstring, ispattern, sme_valid, sme_match;
    logic [4:0] sme_index;
    logic       busy, done, res_match, res_timeout;
    logic [4:0] res_index;

    int checks = 0;
    int errors = 0;

    int n_str, n_pat, first_str, first_pat, wait_cnt, done_cnt, done_tick, busy_bad, order_bad;
    logic done_after, timed_out;
    logic [7:0] str_seen [64];
    logic [7:0] pat_seen [16];

    sme_driver #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .str_len(str_len), .pat_len(pat_len), .start(start),
        .send_str(send_str), .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
        .sme_valid(sme_valid), .sme_match(sme_match), .sme_index(sme_index), .busy(busy),
        .done(done), .res_match(res_match), .res_index(res_index), .res_timeout(res_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_time_limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_buf(input logic sel, input string s);
        for (int i = 0; i < s.len(); i++) begin
            wr_en = 1'b1; wr_sel = sel; wr_addr = 5'(i); wr_data = 8'(s[i]);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic start_job(input logic ss, input logic [5:0] sl, input logic [3:0] pl);
        send_str = ss; str_len = sl; pat_len = pl; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Steps the job cycle by cycle, plays the matcher, records what the DUT emitted.
    task automatic observe(input int vld_after, input logic m, input logic [4:0] idx,
                           input int poke_tick, input int budget);
        int t = 0;
        bit fin = 0;
        n_str = 0; n_pat = 0; first_str = -1; first_pat = -1; wait_cnt = 0;
        done_cnt = 0; done_tick = -1; busy_bad = 0; order_bad = 0;
        while (!fin && t < budget) begin
            tick();
            t++;
            sme_valid = 1'b0; start = 1'b0; wr_en = 1'b0;
            if (isstring) begin
                if (n_pat > 0) order_bad++;
                if (n_str == 0) first_str = t;
                if (n_str < 64) str_seen[n_str] = chardata;
                n_str++;
            end
            if (ispattern) begin
                if (n_pat == 0) first_pat = t;
                if (n_pat < 16) pat_seen[n_pat] = chardata;
                n_pat++;
            end
            if (done) begin
                done_cnt++; done_tick = t; fin = 1;
                if (busy) busy_bad++;
            end else begin
                if (!busy) busy_bad++;
                if (!isstring && !ispattern && n_pat > 0) begin
                    wait_cnt++;
                    if (wait_cnt == vld_after) begin
                        sme_valid = 1'b1; sme_match = m; sme_index = idx;
                    end
                end
            end
            if (t == poke_tick) begin
                start = 1'b1; send_str = 1'b0; str_len = 6'd1; pat_len = 4'd1;
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 5'd31; wr_data = 8'h5a;
            end
        end
        timed_out = !fin;
        tick();
        done_after = done;
        sme_valid = 1'b0; start = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (chardata !== 8'd0) begin errors++; $display("FAIL rst_chardata got %h exp 00", chardata); end
        checks++; if (isstring !== 1'b0) begin errors++; $display("FAIL rst_isstring got %b exp 0", isstring); end
        checks++; if (ispattern !== 1'b0) begin errors++; $display("FAIL rst_ispattern got %b exp 0", ispattern); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
        checks++; if (res_match !== 1'b0) begin errors++; $display("FAIL rst_res_match got %b exp 0", res_match); end
        checks++; if (res_index !== 5'd0) begin errors++; $display("FAIL rst_res_index got %0d exp 0", res_index); end
        checks++; if (res_timeout !== 1'b0) begin errors++; $display("FAIL rst_res_timeout got %b exp 0", res_timeout); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_full_job();
        string es = "hello world";
        string ep = "wor";
        write_buf(1'b0, es);
        write_buf(1'b1, ep);
        start_job(1'b1, 6'd11, 4'd3);
        checks++; if (busy !== 1'b0 || isstring !== 1'b0) begin errors++; $display("FAIL full_start_cycle busy %b isstring %b exp 0 0", busy, isstring); end
        observe(2, 1'b1, 5'd6, -1, 200);
        checks++; if (timed_out) begin errors++; $display("FAIL full_no_done within budget"); end
        checks++; if (n_str !== 11) begin errors++; $display("FAIL full_nstr got %0d exp 11", n_str); end
        checks++; if (n_pat !== 3) begin errors++; $display("FAIL full_npat got %0d exp 3", n_pat); end
        checks++; if (first_str !== 1) begin errors++; $display("FAIL full_first_str got %0d exp 1", first_str); end
        checks++; if (first_pat !== 12) begin errors++; $display("FAIL full_first_pat got %0d exp 12", first_pat); end
        for (int i = 0; i < 11; i++) begin
            checks++; if (str_seen[i] !== 8'(es[i])) begin errors++; $display("FAIL full_str_char[%0d] got %h exp %h", i, str_seen[i], 8'(es[i])); end
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (pat_seen[i] !== 8'(ep[i])) begin errors++; $display("FAIL full_pat_char[%0d] got %h exp %h", i, pat_seen[i], 8'(ep[i])); end
        end
        checks++; if (wait_cnt !== 3) begin errors++; $display("FAIL full_wait_cycles got %0d exp 3", wait_cnt); end
        checks++; if (done_tick !== 18) begin errors++; $display("FAIL full_done_tick got %0d exp 18", done_tick); end
        checks++; if (busy_bad !== 0 || order_bad !== 0) begin errors++; $display("FAIL full_busy_order got %0d %0d exp 0 0", busy_bad, order_bad); end
        checks++; if (res_match !== 1'b1) begin errors++; $display("FAIL full_res_match got %b exp 1", res_match); end
        checks++; if (res_index !== 5'd6) begin errors++; $display("FAIL full_res_index got %0d exp 6", res_index); end
        checks++; if (res_timeout !== 1'b0) begin errors++; $display("FAIL full_res_timeout got %b exp 0", res_timeout); end
        checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL full_done_width got %b exp 0", done_after); end
    endtask

    task automatic test_pattern_only();
        string ep = "^hel";
        write_buf(1'b1, ep);
        start_job(1'b0, 6'd0, 4'd4);
        observe(1, 1'b1, 5'd0, -1, 200);
        checks++; if (timed_out) begin errors++; $display("FAIL pat_no_done within budget"); end
        checks++; if (n_str !== 0) begin errors++; $display("FAIL pat_nstr got %0d exp 0", n_str); end
        checks++; if (n_pat !== 4) begin errors++; $display("FAIL pat_npat got %0d exp 4", n_pat); end
        checks++; if (first_pat !== 1) begin errors++; $display("FAIL pat_first_pat got %0d exp 1", first_pat); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (pat_seen[i] !== 8'(ep[i])) begin errors++; $display("FAIL pat_char[%0d] got %h exp %h", i, pat_seen[i], 8'(ep[i])); end
        end
        checks++; if (done_tick !== 7) begin errors++; $display("FAIL pat_done_tick got %0d exp 7", done_tick); end
        checks++; if (res_match !== 1'b1 || res_index !== 5'd0) begin errors++; $display("FAIL pat_result got %b/%0d exp 1/0", res_match, res_index); end
    endtask

    task automatic test_timeout();
        write_buf(1'b1, "ab");
        start_job(1'b0, 6'd0, 4'd2);
        observe(-1, 1'b0, 5'd0, -1, 200);
        checks++; if (timed_out) begin errors++; $display("FAIL to_no_done within budget"); end
        checks++; if (wait_cnt !== 16) begin errors++; $display("FAIL to_wait_cycles got %0d exp 16", wait_cnt); end
        checks++; if (done_tick !== 19) begin errors++; $display("FAIL to_done_tick got %0d exp 19", done_tick); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL to_done_count got %0d exp 1", done_cnt); end
        checks++; if (res_timeout !== 1'b1) begin errors++; $display("FAIL to_res_timeout got %b exp 1", res_timeout); end
        checks++; if (res_match !== 1'b0 || res_index !== 5'd0) begin errors++; $display("FAIL to_result got %b/%0d exp 0/0", res_match, res_index); end
    endtask

    task automatic test_reject_ignore();
        int bad = 0;
        start_job(1'b1, 6'd5, 4'd0);
        for (int i = 0; i < 10; i++) begin
            if (busy || isstring || ispattern) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rej_patlen0 active cycles got %0d exp 0", bad); end
        bad = 0;
        start_job(1'b1, 6'd0, 4'd3);
        for (int i = 0; i < 10; i++) begin
            if (busy || isstring || ispattern) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rej_strlen0 active cycles got %0d exp 0", bad); end
        // Clamped length, with a start and a write to char 31 poked mid-string.
        start_job(1'b1, 6'd40, 4'd1);
        observe(1, 1'b0, 5'd3, 3, 300);
        checks++; if (timed_out) begin errors++; $display("FAIL clamp_no_done within budget"); end
        checks++; if (n_str !== 32) begin errors++; $display("FAIL clamp_nstr got %0d exp 32", n_str); end
        checks++; if (n_pat !== 1) begin errors++; $display("FAIL clamp_npat got %0d exp 1", n_pat); end
        checks++; if (str_seen[0] !== 8'h68) begin errors++; $display("FAIL clamp_char0 got %h exp 68", str_seen[0]); end
        checks++; if (str_seen[31] !== 8'h00) begin errors++; $display("FAIL ign_wr_char31 got %h exp 00", str_seen[31]); end
        checks++; if (pat_seen[0] !== 8'h61) begin errors++; $display("FAIL clamp_pat0 got %h exp 61", pat_seen[0]); end
        checks++; if (done_tick !== 36) begin errors++; $display("FAIL clamp_done_tick got %0d exp 36", done_tick); end
        checks++; if (res_match !== 1'b0 || res_index !== 5'd3 || res_timeout !== 1'b0) begin errors++; $display("FAIL clamp_result got %b/%0d/%b exp 0/3/0", res_match, res_index, res_timeout); end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy || isstring || ispattern || done) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL ign_start active cycles got %0d exp 0", bad); end
    endtask

    task automatic test_reset_mid_job();
        int bad = 0;
        start_job(1'b1, 6'd4, 4'd3);
        repeat (6) tick();
        checks++; if (ispattern !== 1'b1) begin errors++; $display("FAIL rmid_in_sendp got %b exp 1", ispattern); end
        reset = 1'b1;
        tick();
        checks++; if ({chardata, isstring, ispattern, busy, done, res_match, res_index, res_timeout} !== 19'd0)
            begin errors++; $display("FAIL rmid_outputs got %h/%b%b%b%b%b/%0d/%b exp all 0", chardata, isstring, ispattern, busy, done, res_match, res_index, res_timeout); end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rmid_no_done active cycles got %0d exp 0", bad); end
        start_job(1'b0, 6'd4, 4'd2);
        observe(1, 1'b1, 5'd2, -1, 200);
        checks++; if (timed_out) begin errors++; $display("FAIL rmid_no_done within budget"); end
        checks++; if (n_str !== 4) begin errors++; $display("FAIL rmid_nstr got %0d exp 4", n_str); end
        checks++; if (n_pat !== 2) begin errors++; $display("FAIL rmid_npat got %0d exp 2", n_pat); end
        checks++; if (str_seen[0] !== 8'h00 || str_seen[3] !== 8'h00) begin errors++; $display("FAIL rmid_buf_cleared got %h %h exp 00 00", str_seen[0], str_seen[3]); end
        checks++; if (res_match !== 1'b1 || res_index !== 5'd2) begin errors++; $display("FAIL rmid_result got %b/%0d exp 1/2", res_match, res_index); end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        str_len = '0; pat_len = '0; start = 1'b0; send_str = 1'b0;
        sme_valid = 1'b0; sme_match = 1'b0; sme_index = '0;
        test_reset();
        test_full_job();
        test_pattern_only();
        test_timeout();
        test_reject_ignore();
        test_reset_mid_job();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sme_driver.md
# sme_driver

Transmit-side companion to the string-matching engine. It buffers one string (up to 32 chars) and one pattern (up to 8 chars) written by a host, then serializes them onto the engine's `chardata`/`isstring`/`ispattern` input protocol. It waits for the engine's `valid`, captures `match`/`match_index`, and reports one result per job to the host. It sits between the testbench/host register interface and the matcher, and it also drives pattern-only jobs that reuse the previously sent string.

## Interface
Parameters:
- `STR_MAX`, 32: string buffer depth in chars.
- `PAT_MAX`, 8: pattern buffer depth in chars.
- `TIMEOUT`, 255: maximum WAIT cycles before the job is aborted (8-bit counter).

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `wr_en` in 1: buffer write strobe; honoured only in IDLE.
- `wr_sel` in 1: 0 writes the string buffer, 1 writes the pattern buffer.
- `wr_addr` in 5: char index; for the pattern buffer only bits [2:0] are used.
- `wr_data` in 8: ASCII char.
- `str_len` in 6: string length, 1..32; latched at start.
- `pat_len` in 4: pattern length, 1..8; latched at start.
- `start` in 1: job request; honoured only in IDLE.
- `send_str` in 1: 1 sends string then pattern; 0 sends pattern only. Sampled with `start`.
- `chardata` out 8: char to the engine; registered.
- `isstring` out 1: string char valid; registered.
- `ispattern` out 1: pattern char valid; registered.
- `sme_valid` in 1: engine result strobe.
- `sme_match` in 1: engine match flag.
- `sme_index` in 5: engine match index.
- `busy` out 1: high from the cycle after an accepted start until `done`.
- `done` out 1: one-cycle result pulse.
- `res_match` out 1: captured match flag; held until the next `done`.
- `res_index` out 5: captured match index; held until the next `done`.
- `res_timeout` out 1: 1 if the job was aborted by the watchdog; held until the next `done`.

## Operation
- States: IDLE, SEND_S, SEND_P, WAIT, DONE.
- **IDLE**
  - `wr_en` writes the selected buffer.
  - `start` with valid lengths latches the lengths and moves to SEND_S if `send_str`=1 or `str_loaded`=0; otherwise it moves to SEND_P.
  - `str_len`>32 clamps to 32; `pat_len`>8 clamps to 8.
  - A length of 0 (`str_len` when the string is sent, or `pat_len`) rejects the start: stay in IDLE, `busy` stays 0.
- **SEND_S**: drive `string[k]` with `isstring`=1 for k=0..len-1. After the last char, go straight to SEND_P with no gap cycle. Set `str_loaded`.
- **SEND_P**: drive `pattern[k]` with `ispattern`=1 for k=0..len-1, then go to WAIT.
- **WAIT**
  - Outputs `isstring`=`ispattern`=0 and `chardata`=0.
  - The watchdog counts from 0 each cycle.
  - `sme_valid`=1 captures `sme_match`/`sme_index`, sets `res_timeout`=0, and goes to DONE.
  - If the watchdog reaches `TIMEOUT` without `sme_valid`, set `res_match`=0, `res_index`=0, `res_timeout`=1 and go to DONE.
  - If `sme_valid` and timeout occur in the same cycle, `sme_valid` wins.
- **DONE**: pulse `done` for one cycle, then go to IDLE.
- Ignored inputs:
  - `sme_valid` outside WAIT.
  - `start` and `wr_en` while not in IDLE.
- A write in the same cycle as an accepted start is applied, and is visible to the job.
- Char counter width is 6 bits and compares against the latched length. Counters never wrap.

## Timing
- **Reset values:**
  - `chardata`=0, `isstring`=0, `ispattern`=0, `busy`=0, `done`=0.
  - `res_match`=0, `res_index`=0, `res_timeout`=0.
  - Buffers are cleared to 0, `str_loaded`=0, state is IDLE.
  - Reset mid-job aborts the job immediately; all outputs are 0 on the next cycle and no `done` pulse is produced.
- **Start handshake:** `start` is sampled at edge T. The first char and `busy`=1 appear after edge T+1.
- **Full job length:** `isstring` is high for exactly S cycles, immediately followed by `ispattern` high for exactly P cycles.
- **Done latency:** `sme_valid` sampled at edge W gives `done`=1 during the cycle after edge W+1, together with the updated `res_*`. `busy` drops in that same cycle.
- **Next job:** a new `start` is accepted the cycle after `done`.
- **Job duration:** total cycles from start to done = 1 + S + P + (WAIT cycles) + 1.

## Test plan
- **Full job:** string "hello world" (S=11), pattern "wor" (P=3), start with `send_str`=1.
  - `isstring` high 11 cycles with chars h..d, then `ispattern` high 3 cycles w,o,r.
  - Model returns valid, match=1, index=6 → one `done`, `res_match`=1, `res_index`=6, `res_timeout`=0.
- **Pattern-only reuse:** after the full job, load pattern "^hel" and start with `send_str`=0.
  - No `isstring` cycles; `ispattern` high 4 cycles.
  - Model returns valid, match=1, index=0 → `res_index`=0.
- **Timeout:** `TIMEOUT`=16, model never asserts valid.
  - `done` exactly 16 WAIT cycles after the pattern ends, with `res_timeout`=1 and `res_match`=0.
- **Rejected and ignored requests:**
  - `pat_len`=0 → `busy` stays 0 and no chars are driven.
  - `str_len`=40 → exactly 32 string cycles.
  - `start` and `wr_en` pulsed mid-SEND_S → no effect on the current job or the buffers.
- **Reset mid-job:** assert `reset` during SEND_P char 2.
  - All outputs 0 the next cycle, no `done`.
  - A following start with `send_str`=0 still sends the string first, because `str_loaded` was cleared.
